// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC next-value, single outstanding fetch, redirect/squash
//
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   pc                  : current PC register value
//   pc_next             : combinational next PC, loaded by the PC register every cycle
//   imem_req/addr       : fetch request and registered fetch address
//   imem_ready/rdata    : memory completion and instruction word
//   instr/instr_pc      : held instruction word and its address
//   instr_valid/ready   : decoder handshake
//   redirect_valid/target : single-cycle control-flow redirect
//   fault               : sticky misaligned-redirect flag
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned STEP         = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_SQUASH,
        S_FAULT
    } state_t;

    localparam logic [31:0] STEP_W = 32'(STEP);

    state_t      state_q, state_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fault_q, fault_d;

    logic        redir_ok;
    logic        redir_bad;
    logic        enter_req;

    assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        imem_addr_d = imem_addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        fault_d     = fault_q;
        pc_next     = pc;
        enter_req   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (redir_bad) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    if (redir_ok) pc_next = redirect_target;
                    state_d   = S_REQ;
                    enter_req = 1'b1;
                end
            end

            S_REQ: begin
                if (redir_bad) begin
                    // An outstanding request must still drain before FAULT.
                    fault_d = 1'b1;
                    state_d = imem_ready ? S_FAULT : S_SQUASH;
                end else if (redir_ok) begin
                    pc_next = redirect_target;
                    if (imem_ready) begin
                        // Response is discarded; refetch immediately at the target.
                        state_d   = S_REQ;
                        enter_req = 1'b1;
                    end else begin
                        state_d = S_SQUASH;
                    end
                end else if (imem_ready) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = imem_addr_q;
                    state_d    = S_HOLD;
                end
            end

            S_HOLD: begin
                if (redir_bad) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else if (redir_ok) begin
                    // A same-cycle decoder accept still completes; PC takes the target.
                    pc_next   = redirect_target;
                    state_d   = S_REQ;
                    enter_req = 1'b1;
                end else if (instr_ready) begin
                    pc_next   = pc + STEP_W;
                    state_d   = S_REQ;
                    enter_req = 1'b1;
                end
            end

            S_SQUASH: begin
                if (fault_q) begin
                    // Fault pending: only wait for the stale response, ignore redirects.
                    if (imem_ready) state_d = S_FAULT;
                end else if (redir_bad) begin
                    fault_d = 1'b1;
                    if (imem_ready) state_d = S_FAULT;
                end else begin
                    if (redir_ok) pc_next = redirect_target;
                    if (imem_ready) begin
                        // pc already holds the redirect target (or the newer one).
                        state_d   = S_REQ;
                        enter_req = 1'b1;
                    end
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_req) imem_addr_d = pc_next;

        imem_req_d    = (state_d == S_REQ) || (state_d == S_SQUASH);
        instr_valid_d = (state_d == S_HOLD);

        if (!reset) pc_next = RESET_VECTOR;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= 32'h0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        fault;

    int errors = 0;
    int checks = 0;

    fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .STEP(4)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // PC register of the surrounding core.
    always_ff @(posedge clk) pc <= pc_next;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%0h exp=0", fault); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
        checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr got=%0h/%0h exp=0/0", instr, instr_pc); end
        checks++; if (pc_next !== 32'h0 || pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%0h/%0h exp=0/0", pc_next, pc); end
    endtask

    task automatic test_sequential();
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || pc_next !== 32'h0) begin errors++; $display("FAIL seq_idle got req=%0h pc_next=%0h exp 0/0", imem_req, pc_next); end
        step();
        for (int k = 0; k < 2; k++) begin
            imem_ready = 1'b1; instr_ready = 1'b1; imem_rdata = 32'hD000_0000 + 32'(4 * k);
            #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || pc !== 32'(4 * k) || instr_valid !== 1'b0)
                begin errors++; $display("FAIL seq_req%0d got req=%0h addr=%0h pc=%0h v=%0h exp 1/%0h/%0h/0", k, imem_req, imem_addr, pc, instr_valid, 4 * k, 4 * k); end
            step();
            #1;
            checks++; if (instr_valid !== 1'b1 || instr !== 32'hD000_0000 + 32'(4 * k) || instr_pc !== 32'(4 * k) || imem_req !== 1'b0)
                begin errors++; $display("FAIL seq_hold%0d got v=%0h instr=%0h ipc=%0h req=%0h", k, instr_valid, instr, instr_pc, imem_req); end
            checks++; if (pc_next !== 32'(4 * k + 4)) begin errors++; $display("FAIL seq_pcnext%0d got=%0h exp=%0h", k, pc_next, 4 * k + 4); end
            step();
        end
    endtask

    task automatic test_mem_wait();
        imem_ready = 1'b0; instr_ready = 1'b0;
        repeat (3) begin
            #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0 || pc_next !== 32'h8)
                begin errors++; $display("FAIL wait_req got req=%0h addr=%0h v=%0h pcn=%0h exp 1/8/0/8", imem_req, imem_addr, instr_valid, pc_next); end
            step();
        end
        imem_ready = 1'b1; imem_rdata = 32'hD000_0008;
        step();
        imem_ready = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== 32'hD000_0008)
            begin errors++; $display("FAIL wait_hold got v=%0h ipc=%0h instr=%0h exp 1/8/d0000008", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_decoder_stall();
        instr_ready = 1'b0;
        repeat (4) begin
            #1;
            checks++; if (instr_valid !== 1'b1 || instr !== 32'hD000_0008 || pc_next !== 32'h8 || pc !== 32'h8)
                begin errors++; $display("FAIL stall got v=%0h instr=%0h pcn=%0h pc=%0h", instr_valid, instr, pc_next, pc); end
            step();
        end
        instr_ready = 1'b1;
        #1;
        checks++; if (pc_next !== 32'hC) begin errors++; $display("FAIL stall_accept got=%0h exp=c", pc_next); end
        step();
        instr_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || pc !== 32'hC || instr_valid !== 1'b0)
            begin errors++; $display("FAIL stall_next got req=%0h addr=%0h pc=%0h v=%0h exp 1/c/c/0", imem_req, imem_addr, pc, instr_valid); end
    endtask

    task automatic test_redirect_squash();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h100;
        #1;
        checks++; if (pc_next !== 32'h100) begin errors++; $display("FAIL sq_pcnext got=%0h exp=100", pc_next); end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || pc !== 32'h100 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL sq_enter got req=%0h addr=%0h pc=%0h v=%0h exp 1/c/100/0", imem_req, imem_addr, pc, instr_valid); end
        redirect_valid = 1'b1; redirect_target = 32'h180;
        #1;
        checks++; if (pc_next !== 32'h180) begin errors++; $display("FAIL sq_retarget got=%0h exp=180", pc_next); end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || pc !== 32'h180)
            begin errors++; $display("FAIL sq_hold got req=%0h addr=%0h pc=%0h exp 1/c/180", imem_req, imem_addr, pc); end
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h180 || instr_valid !== 1'b0 || instr !== 32'hD000_0008)
            begin errors++; $display("FAIL sq_drop got req=%0h addr=%0h v=%0h instr=%0h exp 1/180/0/d0000008", imem_req, imem_addr, instr_valid, instr); end
        imem_ready = 1'b1; imem_rdata = 32'hD000_0180;
        step();
        imem_ready = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h180 || instr !== 32'hD000_0180)
            begin errors++; $display("FAIL sq_refetch got v=%0h ipc=%0h instr=%0h exp 1/180/d0000180", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_fault();
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h102;
        #1;
        checks++; if (pc_next !== 32'h180) begin errors++; $display("FAIL flt_pcnext got=%0h exp=180", pc_next); end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++; if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h180)
            begin errors++; $display("FAIL flt_enter got f=%0h req=%0h v=%0h pc=%0h exp 1/0/0/180", fault, imem_req, instr_valid, pc); end
        redirect_valid = 1'b1; redirect_target = 32'h200; instr_ready = 1'b1; imem_ready = 1'b1;
        #1;
        checks++; if (pc_next !== 32'h180) begin errors++; $display("FAIL flt_ignore got=%0h exp=180", pc_next); end
        step();
        redirect_valid = 1'b0; instr_ready = 1'b0; imem_ready = 1'b0;
        #1;
        checks++; if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h180)
            begin errors++; $display("FAIL flt_sticky got f=%0h req=%0h pc=%0h exp 1/0/180", fault, imem_req, pc); end
    endtask

    task automatic test_wrap();
        reset = 1'b0;
        step();
        reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        #1;
        checks++; if (pc_next !== 32'hFFFF_FFFC || fault !== 1'b0) begin errors++; $display("FAIL wrap_redir got pcn=%0h f=%0h exp fffffffc/0", pc_next, fault); end
        step();
        redirect_valid = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hD000_00FC;
        #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%0h exp=fffffffc", imem_addr); end
        step();
        imem_ready = 1'b0; instr_ready = 1'b1;
        #1;
        checks++; if (instr_pc !== 32'hFFFF_FFFC || pc_next !== 32'h0) begin errors++; $display("FAIL wrap_step got ipc=%0h pcn=%0h exp fffffffc/0", instr_pc, pc_next); end
        step();
        instr_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc !== 32'h0 || fault !== 1'b0)
            begin errors++; $display("FAIL wrap_next got req=%0h addr=%0h pc=%0h f=%0h exp 1/0/0/0", imem_req, imem_addr, pc, fault); end
    endtask

    task automatic test_reset_in_squash();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0; reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || pc_next !== 32'h0) begin errors++; $display("FAIL rsq_pre got req=%0h pcn=%0h exp 1/0", imem_req, pc_next); end
        step();
        imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        repeat (2) begin
            #1;
            checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0 || instr_valid !== 1'b0 || fault !== 1'b0 || pc !== 32'h0)
                begin errors++; $display("FAIL rsq_clear got req=%0h addr=%0h instr=%0h ipc=%0h v=%0h f=%0h pc=%0h", imem_req, imem_addr, instr, instr_pc, instr_valid, fault, pc); end
            step();
        end
        reset = 1'b1; imem_ready = 1'b0;
        step();
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL rsq_restart got req=%0h addr=%0h v=%0h exp 1/0/0", imem_req, imem_addr, instr_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_mem_wait();
        test_decoder_stall();
        test_redirect_squash();
        test_fault();
        test_wrap();
        test_reset_in_squash();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
